// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // 2-of-3 majority used to de-noise each bit around its centre.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Input synchroniser for the async serial line, with falling-edge detect.
// Latency: STAGES clocks from din to rx; fall is combinational on the last two flops.
// Backpressure: none, free-running.
//   clk   in   system clock
//   rst_n in   synchronous active-low reset (flops reset to idle-high)
//   din   in   async serial line
//   rx    out  synchronised line
//   fall  out  rx is 1 and the stage before it is 0 (start edge about to appear on rx)
module uart_rx_sync #(
    parameter int STAGES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rx,
    output logic fall
);

    logic [STAGES-1:0] s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s <= '1;
        end else begin
            s <= {s[STAGES-2:0], din};
        end
    end

    assign rx   = s[STAGES-1];
    assign fall = s[STAGES-1] & ~s[STAGES-2];

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: majority-voted sampling, parity/framing/break/overrun flags.
// Latency: dout_vld rises SYNC_STAGES-1 + (frame bits before last stop)*CLK_DIV + CLK_DIV/2 + 2 clocks after din falls.
// Backpressure: dout/flags held until dout_rdy; a frame completing while unaccepted is dropped with overrun_err.
//   clk, rst_n        system clock, synchronous active-low reset
//   din               async serial line, idle high
//   dout, dout_vld    received word and its valid; dout_rdy accepts it
//   parity_err, frame_err, brk_det  flags belonging to the current dout
//   overrun_err       1-cycle pulse when a finished word is dropped
//   busy              receiver is inside a frame
module uart_rx_param #(
    parameter int CLK_DIV     = 217,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 din,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_vld,
    input  logic                 dout_rdy,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 brk_det,
    output logic                 overrun_err,
    output logic                 busy
);
    import uart_pkg::*;

    localparam int CW  = $clog2(CLK_DIV);
    localparam int BW  = $clog2(DATA_BITS + 1);
    localparam int MID = CLK_DIV / 2;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(MID - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(MID);
    localparam logic [CW-1:0] CNT_DEC  = CW'(MID + 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    logic                 rx;
    logic                 fall;
    rx_state_t            state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bitn;
    logic                 samp0;
    logic                 samp1;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr_q;
    logic                 ferr_q;
    logic                 any_one;
    logic [CW-1:0]        idle_cnt;
    logic                 armed;

    logic bit_val;
    logic frame_done;
    logic ferr_now;

    uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (din),
        .rx   (rx),
        .fall (fall)
    );

    // Third sample is the live rx at the decision count.
    assign bit_val    = maj3(samp0, samp1, rx);
    assign frame_done = (state == S_STOP) && (cnt == CNT_DEC) && (bitn == STOP_LAST);
    assign ferr_now   = ferr_q | ~bit_val;
    assign busy       = (state != S_IDLE);

    // Arming: the line must sit high for a full bit time before a start edge counts.
    // A frame ending in a framing error (including a break) disarms until that happens again.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            armed    <= 1'b0;
            idle_cnt <= '0;
        end else if (frame_done && ferr_now) begin
            armed    <= 1'b0;
            idle_cnt <= '0;
        end else if (!rx) begin
            idle_cnt <= '0;
        end else if (idle_cnt == CNT_LAST) begin
            armed <= 1'b1;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            bitn        <= '0;
            samp0       <= 1'b0;
            samp1       <= 1'b0;
            shreg       <= '0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            any_one     <= 1'b0;
            dout        <= '0;
            dout_vld    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            brk_det     <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (dout_vld && dout_rdy) begin
                dout_vld <= 1'b0;
            end
            if (state != S_IDLE) begin
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            end
            if (cnt == CNT_S0) begin
                samp0 <= rx;
            end
            if (cnt == CNT_S1) begin
                samp1 <= rx;
            end

            case (state)
                S_IDLE: begin
                    if (fall && armed) begin
                        state   <= S_START;
                        cnt     <= '0;
                        bitn    <= '0;
                        perr_q  <= 1'b0;
                        ferr_q  <= 1'b0;
                        any_one <= 1'b0;
                    end
                end
                S_START: begin
                    if (cnt == CNT_DEC && bit_val) begin
                        state <= S_IDLE;            // start bit not really low: glitch
                    end else if (cnt == CNT_LAST) begin
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (cnt == CNT_DEC) begin
                        shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
                        any_one <= any_one | bit_val;
                    end
                    if (cnt == CNT_LAST) begin
                        if (bitn == BIT_LAST) begin
                            bitn  <= '0;
                            state <= (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                        end else begin
                            bitn <= bitn + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (cnt == CNT_DEC) begin
                        perr_q  <= (^shreg ^ bit_val) != (PARITY == PAR_ODD);
                        any_one <= any_one | bit_val;
                    end
                    if (cnt == CNT_LAST) begin
                        state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (cnt == CNT_DEC) begin
                        if (bitn == STOP_LAST) begin
                            // Leave at the last decision so a new start edge may
                            // land in the second half of the stop bit.
                            state <= S_IDLE;
                            if (!dout_vld || dout_rdy) begin
                                dout       <= shreg;
                                dout_vld   <= 1'b1;
                                parity_err <= perr_q;
                                frame_err  <= ferr_now;
                                brk_det    <= ~(any_one | bit_val);
                            end else begin
                                overrun_err <= 1'b1;
                            end
                        end else begin
                            ferr_q  <= ferr_now;
                            any_one <= any_one | bit_val;
                        end
                    end else if (cnt == CNT_LAST) begin
                        bitn <= bitn + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: default 8N1 instance plus a 7E2 instance with a short bit time.
// Latency: expected completion cycles derived from the frame timing rule.
// Backpressure: dout_rdy driven by the stimulus; handshake and overrun modelled per word.
`timescale 1ns/1ps
module tb_uart_rx_param;

    localparam int S  = 3;
    localparam int CA = 217;
    localparam int CB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic din_a = 1'b1, din_b = 1'b1;
    logic rdy_a = 1'b0, rdy_b = 1'b0;
    logic [7:0] dout_a;
    logic [6:0] dout_b;
    logic vld_a, pe_a, fe_a, bk_a, ov_a, busy_a;
    logic vld_b, pe_b, fe_b, bk_b, ov_b, busy_b;

    uart_rx_param u_a (
        .clk(clk), .rst_n(rst_n), .din(din_a), .dout(dout_a), .dout_vld(vld_a), .dout_rdy(rdy_a),
        .parity_err(pe_a), .frame_err(fe_a), .brk_det(bk_a), .overrun_err(ov_a), .busy(busy_a)
    );

    uart_rx_param #(.CLK_DIV(CB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .SYNC_STAGES(S)) u_b (
        .clk(clk), .rst_n(rst_n), .din(din_b), .dout(dout_b), .dout_vld(vld_b), .dout_rdy(rdy_b),
        .parity_err(pe_b), .frame_err(fe_b), .brk_det(bk_b), .overrun_err(ov_b), .busy(busy_b)
    );

    int cdiv [2] = '{CA, CB};
    int dbits[2] = '{8, 7};
    int par  [2] = '{0, 2};
    int sbits[2] = '{1, 2};

    int nvec = 0;
    int nfail = 0;
    int cyc = 0;
    int last_t0 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model: one entry per frame the line carries ----------------
    typedef struct {
        int         u;
        int         c;
        logic [8:0] d;
        logic       pe;
        logic       fe;
        logic       bk;
    } ev_t;
    ev_t evq[$];

    bit   [1:0] m_vld = '0, m_pe = '0, m_fe = '0, m_bk = '0, m_ov = '0;
    logic [8:0] m_dout [2] = '{9'd0, 9'd0};

    always @(posedge clk) begin
        cyc++;
        for (int u = 0; u < 2; u++) begin
            bit r;
            int hit;
            r = (u == 0) ? rdy_a : rdy_b;
            hit = -1;
            m_ov[u] = 1'b0;
            if (!rst_n) begin
                m_vld[u] = 1'b0; m_pe[u] = 1'b0; m_fe[u] = 1'b0; m_bk[u] = 1'b0;
                m_dout[u] = '0;
            end else begin
                for (int i = 0; i < evq.size(); i++)
                    if (hit < 0 && evq[i].u == u && evq[i].c == cyc) hit = i;
                if (hit >= 0) begin
                    if (!m_vld[u] || r) begin
                        m_vld[u] = 1'b1;
                        m_dout[u] = evq[hit].d;
                        m_pe[u] = evq[hit].pe;
                        m_fe[u] = evq[hit].fe;
                        m_bk[u] = evq[hit].bk;
                    end else begin
                        m_ov[u] = 1'b1;
                    end
                    evq.delete(hit);
                end else if (m_vld[u] && r) begin
                    m_vld[u] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("a.vld",  vld_a,  m_vld[0]);
            chk("a.dout", dout_a, m_dout[0]);
            chk("a.perr", pe_a,   m_pe[0]);
            chk("a.ferr", fe_a,   m_fe[0]);
            chk("a.brk",  bk_a,   m_bk[0]);
            chk("a.ovr",  ov_a,   m_ov[0]);
            chk("b.vld",  vld_b,  m_vld[1]);
            chk("b.dout", dout_b, m_dout[1]);
            chk("b.perr", pe_b,   m_pe[1]);
            chk("b.ferr", fe_b,   m_fe[1]);
            chk("b.brk",  bk_b,   m_bk[1]);
            chk("b.ovr",  ov_b,   m_ov[1]);
        end
    end

    // First-rise timestamps and overrun pulse count, used by the literal checks.
    int rise_a = 0, rise_b = 0, ovc_a = 0;
    logic pv_a = 1'b0, pv_b = 1'b0;
    always @(negedge clk) begin
        if (vld_a && !pv_a) rise_a = cyc;
        if (vld_b && !pv_b) rise_b = cyc;
        pv_a = vld_a;
        pv_b = vld_b;
        if (ov_a) ovc_a++;
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_din(input int u, input logic v);
        if (u == 0) din_a = v; else din_b = v;
    endtask

    task automatic accept(input int u);
        if (u == 0) rdy_a = 1'b1; else rdy_b = 1'b1;
        @(negedge clk);
        if (u == 0) rdy_a = 1'b0; else rdy_b = 1'b0;
    endtask

    // Sends one frame. stop0 forces stop bits low; glitch inverts the sample at the bit centre
    // of every data bit; rst_bit pulses reset for one cycle mid that bit; rdy_pulse raises
    // dout_rdy exactly in the completion cycle.
    task automatic send(input int u, input logic [8:0] d, input bit pflip, input bit stop0,
                        input bit expect_rx, input bit glitch, input int rst_bit, input bit rdy_pulse);
        logic bits[$];
        logic [8:0] dm;
        logic px, pb;
        int c, t0, comp;
        ev_t e;
        c = cdiv[u];
        dm = '0;
        px = 1'b0;
        pb = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < dbits[u]; i++) begin
            bits.push_back(d[i]);
            dm[i] = d[i];
            px = px ^ d[i];
        end
        if (par[u] != 0) begin
            pb = px ^ (par[u] == 1) ^ pflip;
            bits.push_back(pb);
        end
        for (int i = 0; i < sbits[u]; i++) bits.push_back(!stop0);
        t0 = cyc + 1;
        last_t0 = t0;
        comp = t0 + (S - 1) + (bits.size() - 1) * c + c / 2 + 2;
        if (expect_rx) begin
            e.u = u; e.c = comp; e.d = dm;
            e.pe = (par[u] != 0) && pflip;
            e.fe = stop0;
            e.bk = (dm == 0) && (pb == 1'b0) && stop0;
            evq.push_back(e);
        end
        for (int k = 0; k < bits.size(); k++) begin
            for (int j = 0; j < c; j++) begin
                set_din(u, bits[k] ^ (glitch && k >= 1 && k <= dbits[u] && j == c / 2));
                rst_n = !(k == rst_bit && j == c / 2);
                if (rdy_pulse) begin
                    if (u == 0) rdy_a = (cyc == comp - 1); else rdy_b = (cyc == comp - 1);
                end
                @(negedge clk);
            end
        end
        rst_n = 1'b1;
        if (rdy_pulse) begin
            if (u == 0) rdy_a = 1'b0; else rdy_b = 1'b0;
        end
    endtask

    initial begin
        int t0;
        idle(3);
        chk("reset_vld", vld_a, 0);
        chk("reset_busy", busy_a, 0);
        rst_n = 1'b1;
        idle(300);

        // 1: 0xA5 8N1, fixed latency, word held until accepted
        send(0, 9'hA5, 0, 0, 1, 0, -1, 0);
        chk("t1_latency", rise_a - last_t0, 2065);
        chk("t1_dout", dout_a, 8'hA5);
        chk("t1_flags", {pe_a, fe_a, bk_a}, 3'b000);
        idle(20);
        chk("t1_hold", vld_a, 1);
        accept(0);
        chk("t1_accepted", vld_a, 0);

        // 2: 7E2, correct then flipped parity
        send(1, 9'h55, 0, 0, 1, 0, -1, 0);
        chk("t2_latency", rise_b - last_t0, 172);
        chk("t2_dout_ok", dout_b, 7'h55);
        chk("t2_perr_ok", pe_b, 0);
        accept(1);
        idle(5);
        send(1, 9'h55, 1, 0, 1, 0, -1, 0);
        chk("t2_dout_bad", dout_b, 7'h55);
        chk("t2_perr_bad", pe_b, 1);
        accept(1);

        // 3: 40-cycle low glitch, then a real frame
        idle(20);
        din_a = 1'b0;
        t0 = cyc + 1;
        repeat (40) @(negedge clk);
        din_a = 1'b1;
        while (cyc < t0 + 111) @(negedge clk);
        chk("t3_busy_before_dec", busy_a, 1);
        @(negedge clk);
        chk("t3_busy_after_dec", busy_a, 0);
        chk("t3_no_word", vld_a, 0);
        idle(20);
        send(0, 9'h3C, 0, 0, 1, 0, -1, 0);
        chk("t3_dout", dout_a, 8'h3C);
        accept(0);

        // 4: break, then an early frame that must be ignored, then a good frame
        idle(20);
        send(0, 9'h00, 0, 1, 1, 0, -1, 0);
        idle(2 * CA);
        chk("t4_dout", dout_a, 8'h00);
        chk("t4_ferr", fe_a, 1);
        chk("t4_brk", bk_a, 1);
        accept(0);
        din_a = 1'b1;
        idle(CA / 2);
        send(0, 9'h00, 0, 0, 0, 0, -1, 0);
        chk("t4_unarmed_ignored", vld_a, 0);
        idle(2 * CA);
        send(0, 9'hC3, 0, 0, 1, 0, -1, 0);
        chk("t4_rearmed_dout", dout_a, 8'hC3);
        chk("t4_rearmed_flags", {fe_a, bk_a}, 2'b00);
        accept(0);

        // 5: overrun with rdy low, then accept on the completion cycle
        idle(20);
        send(0, 9'h11, 0, 0, 1, 0, -1, 0);
        send(0, 9'h22, 0, 0, 1, 0, -1, 0);
        chk("t5_kept_old", dout_a, 8'h11);
        chk("t5_ovr_pulses", ovc_a, 1);
        send(0, 9'h22, 0, 0, 1, 0, -1, 1);
        chk("t5_swap_dout", dout_a, 8'h22);
        chk("t5_swap_vld", vld_a, 1);
        chk("t5_no_new_ovr", ovc_a, 1);

        // 6: reset mid data bit 4 while 0x22 is still held
        send(0, 9'h0F, 0, 0, 0, 0, 5, 0);
        chk("t6_vld_cleared", vld_a, 0);
        chk("t6_dout_cleared", dout_a, 8'h00);
        idle(2 * CA);
        send(0, 9'h96, 0, 0, 1, 0, -1, 0);
        chk("t6_after_reset", dout_a, 8'h96);
        accept(0);

        // 7: one inverted sample at each data-bit centre
        idle(20);
        send(0, 9'h69, 0, 0, 1, 1, -1, 0);
        chk("t7_majority", dout_a, 8'h69);
        chk("t7_flags", {pe_a, fe_a, bk_a}, 3'b000);
        accept(0);
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
